// File: rtl/popcount_pkg.sv
// popcount_pkg: shared sizing helpers for the pipelined bit counter.
//   cnt_width    - width of one slice count, range 0..CHUNK
//   out_width    - width of the final count, range 0..WIDTH
//   pipe_latency - number of register stages from input to data_o
//   lvl_count    - number of adder-tree nodes on a given level
//   lvl_offset   - bit offset of a tree level inside the flattened tree vector
package popcount_pkg;

  function automatic int unsigned cnt_width(input int unsigned chunk);
    return $clog2(chunk) + 1;
  endfunction

  function automatic int unsigned out_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  function automatic int unsigned pipe_latency(input int unsigned width, input int unsigned chunk);
    if (chunk == 0) return 2;
    return 2 + $clog2(width / chunk);
  endfunction

  // Each level halves the node count, rounding up (an odd node passes through).
  function automatic int unsigned lvl_count(input int unsigned nch, input int unsigned lvl);
    int unsigned n;
    n = nch;
    for (int unsigned k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Level k nodes are cw+k bits wide; levels are packed back to back from level 0.
  function automatic int unsigned lvl_offset(input int unsigned nch, input int unsigned cw,
                                             input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < lvl; k++) off += lvl_count(nch, k) * (cw + k);
    return off;
  endfunction

endpackage

// File: rtl/popcount_pipe_if.sv
// popcount_pipe_if: word/result handshake bundle for popcount_pipe.
//   data_val_i, data_i, cnt_zeros_i - input word, valid strobe and per-word mode
//   data_val_o, data_o              - result valid pulse and bit count (0..WIDTH)
//   data_last_i, acc_val_o, acc_o   - frame accumulator signals, POPCNT_ACCUM_EN only
// Modports: master drives words (producer side), slave is the counter.
interface popcount_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = 16
) ();
  import popcount_pkg::*;

  localparam int unsigned OW = out_width(WIDTH);

  if (WIDTH < 1 || ACC_W < 1) begin : g_bad_cfg
    $error("popcount_pipe_if: WIDTH and ACC_W must be >= 1");
  end

  logic             data_val_i;
  logic [WIDTH-1:0] data_i;
  logic             cnt_zeros_i;
  logic             data_val_o;
  logic [OW-1:0]    data_o;
`ifdef POPCNT_ACCUM_EN
  logic             data_last_i;
  logic             acc_val_o;
  logic [ACC_W-1:0] acc_o;

  modport master (
    output data_val_i, data_i, cnt_zeros_i, data_last_i,
    input  data_val_o, data_o, acc_val_o, acc_o
  );

  modport slave (
    input  data_val_i, data_i, cnt_zeros_i, data_last_i,
    output data_val_o, data_o, acc_val_o, acc_o
  );
`else
  modport master (
    output data_val_i, data_i, cnt_zeros_i,
    input  data_val_o, data_o
  );

  modport slave (
    input  data_val_i, data_i, cnt_zeros_i,
    output data_val_o, data_o
  );
`endif

endinterface

// File: rtl/popcount_chunk.sv
// popcount_chunk: counts the ones in one CHUNK-bit slice and registers the result.
//   i_clk  - clock, rising edge
//   i_en   - load a new count (slice data is valid this cycle)
//   i_clr  - synchronous clear of the registered count
//   i_data - slice bits
//   o_cnt  - registered count, 0..CHUNK
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic                        i_clk,
  input  logic                        i_en,
  input  logic                        i_clr,
  input  logic [CHUNK-1:0]            i_data,
  output logic [cnt_width(CHUNK)-1:0] o_cnt
);

  localparam int unsigned CW = cnt_width(CHUNK);

  logic [CW-1:0] w_cnt;
  logic [CW-1:0] r_cnt;

  always_comb begin
    w_cnt = '0;
    for (int b = 0; b < CHUNK; b++) w_cnt = w_cnt + CW'(i_data[b]);
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/popcount_pipe.sv
// popcount_pipe: fully pipelined ones/zeros counter, one word per cycle, no backpressure.
//   clk_i  - clock, rising edge
//   srst_i - synchronous reset, active-low; flushes every in-flight word
//   bus    - popcount_pipe_if.slave (word in, count out, optional frame total)
// Latency L = 2 + $clog2(WIDTH/CHUNK): input register, slice counters, then one
// registered pairwise adder level per stage, the last level feeding data_o directly.
// Optional feature (macro POPCNT_ACCUM_EN): per-frame saturating accumulator of the
// counts, closed by data_last_i and reported on acc_val_o/acc_o in the result cycle.
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned ACC_W = 16
) (
  input logic            clk_i,
  input logic            srst_i,
  popcount_pipe_if.slave bus
);

  localparam int unsigned NCH    = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(CHUNK);
  localparam int unsigned OW     = out_width(WIDTH);
  localparam int unsigned D      = $clog2(NCH);
  localparam int unsigned L      = pipe_latency(WIDTH, CHUNK);
  localparam int unsigned TREE_W = lvl_offset(NCH, CW, D + 1);
  localparam int unsigned OUT_OF = lvl_offset(NCH, CW, D);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0 || ACC_W < 1) begin : g_bad_cfg
    $error("popcount_pipe: WIDTH must be >= 1 and a multiple of CHUNK, ACC_W >= 1");
  end

  // r_val[s] is the valid bit of the word leaving stage s+1.
  logic [L-1:0]     r_val;
  logic [WIDTH-1:0] r_word;
  logic [TREE_W-1:0] w_tree;
  logic             w_chunk_clr;

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      r_val <= '0;
    end else begin
      r_val <= {r_val[L-2:0], bus.data_val_i};
    end
  end

  // Zeros mode is folded into the input register so the rest of the pipe only counts ones.
  always_ff @(posedge clk_i) begin
    if (bus.data_val_i) begin
      r_word <= bus.cnt_zeros_i ? ~bus.data_i : bus.data_i;
    end
  end

  // With a single slice the chunk register is the output register and must clear on reset.
  assign w_chunk_clr = (D == 0) ? ~srst_i : 1'b0;

  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    popcount_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .i_clk  (clk_i),
      .i_en   (r_val[0]),
      .i_clr  (w_chunk_clr),
      .i_data (r_word[c*CHUNK +: CHUNK]),
      .o_cnt  (w_tree[c*CW +: CW])
    );
  end

  // Adder tree: level j reads level j-1 from w_tree and writes its own slice back.
  for (genvar j = 1; j <= D; j++) begin : g_lvl
    localparam int unsigned NI = lvl_count(NCH, j - 1);
    localparam int unsigned NO = lvl_count(NCH, j);
    localparam int unsigned WI = CW + j - 1;
    localparam int unsigned WO = CW + j;
    localparam int unsigned OI = lvl_offset(NCH, CW, j - 1);
    localparam int unsigned OO = lvl_offset(NCH, CW, j);

    for (genvar i = 0; i < NO; i++) begin : g_node
      logic [WO-1:0] w_add;
      logic [WO-1:0] r_node;

      if (2 * i + 1 < NI) begin : g_pair
        assign w_add = WO'(w_tree[OI + 2*i*WI +: WI]) + WO'(w_tree[OI + (2*i+1)*WI +: WI]);
      end else begin : g_odd
        assign w_add = WO'(w_tree[OI + 2*i*WI +: WI]);
      end

      if (j == D) begin : g_out
        always_ff @(posedge clk_i) begin
          if (!srst_i) begin
            r_node <= '0;
          end else if (r_val[j]) begin
            r_node <= w_add;
          end
        end
      end else begin : g_mid
        always_ff @(posedge clk_i) begin
          if (r_val[j]) begin
            r_node <= w_add;
          end
        end
      end

      assign w_tree[OO + i*WO +: WO] = r_node;
    end
  end

  // The tree result is never wider than WIDTH needs, so truncation is lossless.
  assign bus.data_o     = w_tree[OUT_OF +: OW];
  assign bus.data_val_o = r_val[L-1];

`ifdef POPCNT_ACCUM_EN
  localparam int unsigned SW = ((ACC_W > OW) ? ACC_W : OW) + 1;

  logic [L-1:0]     r_last;
  logic [ACC_W-1:0] r_run;
  logic [SW-1:0]    w_sum;
  logic [ACC_W-1:0] w_sat;
  logic             w_acc_val;

  // Qualified by r_val at the output, so it needs neither reset nor enable.
  always_ff @(posedge clk_i) begin
    r_last <= {r_last[L-2:0], bus.data_last_i};
  end

  assign w_sum     = SW'(r_run) + SW'(bus.data_o);
  assign w_sat     = (|w_sum[SW-1:ACC_W]) ? '1 : w_sum[ACC_W-1:0];
  assign w_acc_val = bus.data_val_o & r_last[L-1];

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      r_run <= '0;
    end else if (bus.data_val_o) begin
      r_run <= r_last[L-1] ? '0 : w_sat;
    end
  end

  assign bus.acc_val_o = w_acc_val;
  assign bus.acc_o     = w_acc_val ? w_sat : '0;
`endif

endmodule

// File: doc/popcount_pipe.md
Name: popcount_pipe

Overview:
- Parametrised, fully pipelined bit counter. Next generation of the single-word ones-counter.
- Accepts one WIDTH-bit word per cycle with a valid strobe.
- Splits the word into CHUNK-bit slices, counts each slice, then sums the slice counts through a registered adder tree.
- Adds a per-word ones/zeros count mode and a fixed, parameter-derived latency; sits directly behind input-capture logic in the datapath.

Parameters:
- WIDTH, 32, input word width; must be ≥1 and divisible by CHUNK (elaboration error otherwise).
- CHUNK, 8, bits per first-stage slice; NCH = WIDTH/CHUNK slices.
- ACC_W, 16, width of the frame accumulator (used only with the optional feature).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  synchronous reset, active-low.
- data_val_i  in  1  input word valid.
- data_i  in  WIDTH  input word.
- cnt_zeros_i  in  1  mode for this word: 0 = count ones, 1 = count zeros; sampled with data_val_i.
- data_val_o  out  1  result valid, one-cycle pulse per input word.
- data_o  out  $clog2(WIDTH)+1  bit count of the word, range 0..WIDTH.
- data_last_i  in  1  last word of a frame (present only with POPCNT_ACCUM_EN).
- acc_val_o  out  1  frame total valid (present only with POPCNT_ACCUM_EN).
- acc_o  out  ACC_W  frame total (present only with POPCNT_ACCUM_EN).

Behaviour:
Reset
- srst_i=0 at a clock edge clears every pipeline valid bit.
- Outputs forced to 0: data_val_o, data_o, acc_val_o, acc_o.
- In-flight words are discarded and never emitted.
- Data-only pipeline registers need no reset.

Pipeline (L = 2 + $clog2(NCH) stages)
- Stage 1: register data_i, cnt_zeros_i and data_val_i. In zeros mode the registered word is inverted.
- Stage 2: per-slice popcount, each result $clog2(CHUNK)+1 bits wide, registered.
- Stages 3..L: one pairwise adder level per stage. An odd operand passes through, added with 0. Each level widens by 1 bit; the final result is truncated to the output width without loss.
- The final level registers directly into data_o.

Timing and throughput
- Latency: word sampled at edge k → data_val_o=1 after edge k+L−1, i.e. visible in the L-th cycle after sampling.
- Example: WIDTH=32, CHUNK=8 → L=4. NCH=1 → L=2.
- Full throughput: back-to-back words produce back-to-back results, in order. No backpressure.
- data_o updates only with valid words and holds its last value while data_val_o=0.
- Valid gaps in the input are preserved exactly at the output.

Boundary values
- All-zeros word gives 0 in ones mode and WIDTH in zeros mode.
- WIDTH itself must be representable in data_o; the extra MSB guarantees it.

Optional Feature:
Macro POPCNT_ACCUM_EN.

Defined:
- A frame accumulator sums data_o of every valid result.
- data_last_i travels through the pipeline alongside its word.
- On the result cycle carrying last: acc_o = running sum + this count, acc_val_o=1 for one cycle, and the running sum restarts at 0 from the next word.
- The sum saturates at 2^ACC_W−1 and never wraps.
- Reset clears the running sum.
- A last on a single-word frame emits that word's count.

Undefined:
- data_last_i, acc_val_o and acc_o ports are absent. No accumulator logic.

Decomposition:
- Package popcount_pkg holds:
  - the function computing L from WIDTH and CHUNK;
  - the output-width function $clog2(WIDTH)+1;
  - the slice-count width constant function.
- One sub-module: popcount_chunk, a combinational-plus-register slice counter (CHUNK in, count out), instantiated NCH times in stage 2.
- The adder tree is built with generate loops in the top.

Test Plan:
All scenarios use WIDTH=32, CHUNK=8 unless stated; L=4.
1. Reset: hold srst_i=0 for 3 cycles with data_val_i=1 → data_val_o=0, data_o=0 throughout and for 3 cycles after release.
2. Single word: 0xF0F0_0001, ones mode, one cycle → exactly one data_val_o pulse 4 cycles after sampling, data_o=9; zeros mode on the same word → 23.
3. Extremes: 0xFFFF_FFFF ones → 32; 0x0000_0000 ones → 0; 0x0000_0000 zeros → 32.
4. Streaming: 100 consecutive random words with random modes → 100 consecutive valid results, in order, matching the reference model; random valid gaps are reproduced exactly.
5. Reset mid-flight: 3 words in the pipe, then srst_i=0 for 1 cycle → none of the 3 emerge; a word sent after reset produces a correct result at latency 4.
6. With POPCNT_ACCUM_EN, ACC_W=6: frame of 0xFFFF_FFFF, 0xFFFF_FFFF, then 0x1 with last → acc_val_o pulse, acc_o=63 (saturated); the next single-word frame 0x3 with last → acc_o=2.
